// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared FSM state and policy definitions for the bus arbiter
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - priority encoder that starts its search at ptr and wraps N-1 -> 0
module arb_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           valid
);

  logic [IDW-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = '0;
    for (int i = 0; i < N; i++) begin
      pos = IDW'((int'(ptr) + i) % N);
      if (!valid && req[pos]) begin
        valid       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_param.sv
// rtl/bus_arbiter_param.sv - N-master bus arbiter with fixed/RR policy, hold timeout and one split slot
module bus_arbiter_param
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int RR_MODE   = ARB_FIXED,
  parameter int TIMEOUT   = 255,
  parameter int IDW       = $clog2(N_MASTERS),
  parameter int TW        = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] done,
  input  logic                 split,
  input  logic                 split_resume,
  output logic [N_MASTERS-1:0] grant,
  output logic [IDW-1:0]       grant_id,
  output logic                 bus_busy,
  output logic                 timeout_err,
  output logic                 split_pending
);

  arb_state_e           state;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       split_id;
  logic                 split_resumed;
  logic [TW-1:0]        hold_cnt;

  logic [N_MASTERS-1:0] park_mask;
  logic [N_MASTERS-1:0] eligible;
  logic [IDW-1:0]       pick_ptr;
  logic [N_MASTERS-1:0] pick_onehot;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_valid;

  logic                 resume_win;
  logic                 resume_drop;
  logic                 win_valid;
  logic [IDW-1:0]       win_idx;
  logic [N_MASTERS-1:0] win_onehot;
  logic [IDW-1:0]       next_ptr;

  logic                 done_hit;
  logic                 req_low;
  logic                 split_hit;
  logic                 to_hit;
  logic                 release_now;

  // A parked master stays out of arbitration until its resume is consumed
  always_comb begin
    park_mask = '0;
    if (split_pending) park_mask[split_id] = 1'b1;
  end

  assign eligible = req & ~park_mask;
  assign pick_ptr = (RR_MODE == ARB_RR) ? rr_ptr : '0;

  arb_pick #(
    .N   (N_MASTERS),
    .IDW (IDW)
  ) u_pick (
    .req    (eligible),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign resume_win  = split_pending && split_resumed && req[split_id];
  assign resume_drop = split_pending && split_resumed && !req[split_id];
  assign win_valid   = resume_win || pick_valid;
  assign win_idx     = resume_win ? split_id : pick_idx;
  assign next_ptr    = (win_idx == IDW'(N_MASTERS - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    win_onehot = pick_onehot;
    if (resume_win) begin
      win_onehot           = '0;
      win_onehot[split_id] = 1'b1;
    end
  end

  // Release causes; done outranks split and timeout, split outranks timeout
  assign done_hit    = done[grant_id];
  assign req_low     = !req[grant_id];
  assign split_hit   = split && !split_pending;
  assign to_hit      = (hold_cnt == TW'(TIMEOUT - 1));
  assign release_now = done_hit || req_low || split_hit || to_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= '0;
      grant_id      <= '0;
      bus_busy      <= 1'b0;
      timeout_err   <= 1'b0;
      split_pending <= 1'b0;
      split_id      <= '0;
      split_resumed <= 1'b0;
      rr_ptr        <= '0;
      hold_cnt      <= '0;
    end else begin
      timeout_err <= 1'b0;
      if (split_resume && split_pending) split_resumed <= 1'b1;

      case (state)
        HOLD: begin
          if (release_now) begin
            grant       <= '0;
            bus_busy    <= 1'b0;
            hold_cnt    <= '0;
            state       <= TURN;
            timeout_err <= to_hit && !done_hit && !req_low && !split_hit;
            if (split_hit && !done_hit) begin
              split_pending <= 1'b1;
              split_id      <= grant_id;
              split_resumed <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        // IDLE and TURN both arbitrate; TURN exists so a release always leaves one idle cycle
        default: begin
          if (resume_win || resume_drop) begin
            split_pending <= 1'b0;
            split_resumed <= 1'b0;
          end
          if (win_valid) begin
            grant    <= win_onehot;
            grant_id <= win_idx;
            bus_busy <= 1'b1;
            hold_cnt <= '0;
            state    <= HOLD;
            if (RR_MODE == ARB_RR) rr_ptr <= next_ptr;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
